// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch FSM state, error codes, reset NOP and default reset PC live here
// so the top, the optional timeout counter and any checker agree on encodings.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BUS      = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // addi x0, x0, 0 -- what the core sees before the first real fetch
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Only the two low bits decide word alignment.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Response timeout counter for the fetch unit (used only when IFU_TIMEOUT_EN
// is defined). Counts WAIT cycles that pass without a response; expired_o is
// raised combinationally in the cycle that would complete the LIMIT-th such
// cycle, so the FSM leaves WAIT after exactly LIMIT silent cycles.
module ifu_timeout_ctr
  import ifu_pkg::*;
#(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,   // entering WAIT: restart the count
  input  logic tick_i,    // a WAIT cycle with no resp_valid
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over tick so a fresh WAIT always starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A response in the limit cycle suppresses tick_i, so it beats the timeout.
  assign expired_o = tick_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage in front of the single-cycle core.
// Owns the architectural PC, issues one word fetch at a time and presents a
// registered {pc_out, inst_out} pair until the core accepts it, then loads the
// core's npc and fetches again. Any fault parks the unit in HALT until reset.
//
// Handshakes: the request channel transfers when req_valid && req_ready on a
// rising edge; req_valid, once high, stays high with req_addr stable until that
// transfer. The response channel is valid-only: resp_valid is a one-cycle pulse
// and is honoured only in WAIT. The core channel transfers when
// inst_valid && inst_ready; pc_out/inst_out are stable while inst_valid waits.
//
// Optional build macro IFU_TIMEOUT_EN: adds a WAIT-cycle watchdog that halts
// with err_code 11 after TIMEOUT_CYCLES silent cycles. Without it WAIT waits
// forever and code 11 never appears.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  input  logic [31:0] npc,
  output logic        fetch_err,
  output logic [1:0]  err_code,
  output logic [2:0]  dbg_state
);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_out_q;
  logic [31:0] inst_out_q;
  logic        inst_valid_q;
  logic        req_valid_q;
  logic        fetch_err_q;
  logic [1:0]  err_code_q;
  logic        tmo_expired;

`ifdef IFU_TIMEOUT_EN
  // Watchdog restarts on the request transfer and ticks on silent WAIT cycles.
  ifu_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  ((state_q == REQ) && req_ready),
    .tick_i   ((state_q == WAIT) && !resp_valid),
    .expired_o(tmo_expired)
  );
`else
  // No watchdog: WAIT never expires. The parameter still shapes the interface
  // so both builds can be instantiated identically.
  assign tmo_expired = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Fetch FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pc_out_q     <= RESET_PC;
      inst_out_q   <= NOP_INST;
      inst_valid_q <= 1'b0;
      req_valid_q  <= 1'b0;
      fetch_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          // One quiet cycle after reset, then the first request.
          state_q     <= REQ;
          req_valid_q <= 1'b1;
        end
        REQ: begin
          // Stray responses here are ignored; nothing is outstanding yet.
          if (req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_valid) begin
            if (resp_err) begin
              // Error wins even when data arrives alongside it.
              state_q     <= HALT;
              fetch_err_q <= 1'b1;
              err_code_q  <= ERR_BUS;
            end else begin
              state_q      <= HOLD;
              inst_out_q   <= resp_data;
              pc_out_q     <= pc_q;
              inst_valid_q <= 1'b1;
            end
          end else if (tmo_expired) begin
            state_q     <= HALT;
            fetch_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            if (is_word_aligned(npc[1:0])) begin
              // Only path that moves the PC; no wrap check on purpose.
              pc_q        <= npc;
              state_q     <= REQ;
              req_valid_q <= 1'b1;
            end else begin
              // PC keeps the address of the last good instruction.
              state_q     <= HALT;
              fetch_err_q <= 1'b1;
              err_code_q  <= ERR_MISALIGN;
            end
          end
        end
        HALT: begin
          // Parked until reset.
        end
        default: begin
          state_q      <= HALT;
          inst_valid_q <= 1'b0;
          req_valid_q  <= 1'b0;
          fetch_err_q  <= 1'b1;
        end
      endcase
    end
  end

  assign req_valid  = req_valid_q;
  assign req_addr   = pc_q;
  assign inst_valid = inst_valid_q;
  assign pc_out     = pc_out_q;
  assign inst_out   = inst_out_q;
  assign fetch_err  = fetch_err_q;
  assign err_code   = err_code_q;
  assign dbg_state  = state_q;

endmodule
